// File: rtl/data_cache.sv
// Write-back, write-allocate, 2-way set-associative data cache for the MEM stage.
// Refills whole lines over a request/acknowledge memory port, writing back dirty victims first.
module data_cache #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rd_req,
  input  logic [3:0]                        wr_req,
  input  logic [31:0]                       addr,
  input  logic [31:0]                       wr_data,
  output logic [31:0]                       rd_data,
  output logic                              miss,
  output logic                              mem_req,
  output logic                              mem_we,
  output logic [29-LINE_ADDR_LEN:0]         mem_addr,
  output logic [(32<<LINE_ADDR_LEN)-1:0]    mem_wdata,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]    mem_rdata,
  input  logic                              mem_ack,
  output logic [31:0]                       access_count,
  output logic [31:0]                       miss_count
);
  localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
  localparam int LINE_W       = 32 << LINE_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, INSTALL} state_t;

  state_t state_q, state_d;
  logic   victim_q, victim_d;
  logic [29-LINE_ADDR_LEN:0] line_addr_q, line_addr_d;
  logic [LINE_W-1:0]         fill_q;

  logic [LINE_W-1:0]       line_q [2][SETS];
  logic [TAG_ADDR_LEN-1:0] tag_q  [2][SETS];
  logic [1:0][SETS-1:0]    valid_q, dirty_q;
  logic [SETS-1:0]         lru_q;
  logic [31:0]             access_count_q, miss_count_q;

  logic [LINE_ADDR_LEN-1:0] word_off;
  logic [SET_ADDR_LEN-1:0]  set_idx, miss_set;
  logic [TAG_ADDR_LEN-1:0]  tag;
  logic req, wr, hit0, hit1, hit, hit_way, v_way, v_dirty;
  logic [LINE_W-1:0] hit_line, merged;
  logic unused_addr_bits;

  assign word_off = addr[LINE_ADDR_LEN+1:2];
  assign set_idx  = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
  assign tag      = addr[31 -: TAG_ADDR_LEN];
  assign miss_set = line_addr_q[SET_ADDR_LEN-1:0];
  assign unused_addr_bits = &{1'b0, addr[1:0]};

  assign req  = rd_req | (|wr_req);
  assign wr   = |wr_req;
  assign hit0 = valid_q[0][set_idx] && (tag_q[0][set_idx] == tag);
  assign hit1 = valid_q[1][set_idx] && (tag_q[1][set_idx] == tag);
  assign hit  = req && (state_q == IDLE) && (hit0 || hit1);
  assign hit_way  = hit0 ? 1'b0 : 1'b1;
  assign hit_line = line_q[hit_way][set_idx];
  assign rd_data  = hit_line[{word_off, 5'b0} +: 32];
  assign miss     = (state_q != IDLE) || (req && !hit);

  // Fill invalid ways before evicting; otherwise the LRU bit names the victim.
  assign v_way   = !valid_q[0][set_idx] ? 1'b0 : (!valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx]);
  assign v_dirty = valid_q[v_way][set_idx] && dirty_q[v_way][set_idx];

  always_comb begin
    merged = hit_line;
    for (int b = 0; b < 4; b++) begin
      if (wr_req[b]) merged[{word_off, 5'b0} + b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  assign mem_addr  = (state_q == SWAP_OUT) ? {tag_q[victim_q][miss_set], miss_set} : line_addr_q;
  assign mem_wdata = line_q[victim_q][miss_set];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    victim_d    = victim_q;
    line_addr_d = line_addr_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          line_addr_d = {tag, set_idx};
          victim_d    = v_way;
          state_d     = v_dirty ? SWAP_OUT : SWAP_IN;
        end
      end
      SWAP_OUT: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = SWAP_IN;
      end
      SWAP_IN: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = INSTALL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      victim_q       <= 1'b0;
      line_addr_q    <= '0;
      valid_q        <= '0;
      dirty_q        <= '0;
      lru_q          <= '0;
      access_count_q <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      line_addr_q <= line_addr_d;
      if (hit) begin
        lru_q[set_idx] <= ~hit_way;
        if (wr) dirty_q[hit_way][set_idx] <= 1'b1;
        access_count_q <= access_count_q + 32'd1;
      end
      if ((state_q == IDLE) && req && !hit) miss_count_q <= miss_count_q + 32'd1;
      if (state_q == INSTALL) begin
        valid_q[victim_q][miss_set] <= 1'b1;
        dirty_q[victim_q][miss_set] <= 1'b0;
        lru_q[miss_set]             <= ~victim_q;
      end
    end
  end

  // NOTE: line and tag storage is deliberately not reset; the valid bits make stale contents harmless.
  always_ff @(posedge clk) begin
    if ((state_q == SWAP_IN) && mem_ack) fill_q <= mem_rdata;
    if (!rst) begin
      if (hit && wr) line_q[hit_way][set_idx] <= merged;
      if (state_q == INSTALL) begin
        line_q[victim_q][miss_set] <= fill_q;
        tag_q[victim_q][miss_set]  <= line_addr_q[29-LINE_ADDR_LEN -: TAG_ADDR_LEN];
      end
    end
  end

  assign access_count = access_count_q;
  assign miss_count   = miss_count_q;
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: behavioural line memory with programmable latency,
// one task per scenario with hand-computed expectations.
module tb_data_cache;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_req = 1'b0;
  logic [3:0]   wr_req = 4'b0;
  logic [31:0]  addr = '0, wr_data = '0;
  logic [31:0]  rd_data;
  logic         miss, mem_req, mem_we;
  logic [26:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata = '0;
  logic         mem_ack = 1'b0;
  logic [31:0]  access_count, miss_count;

  int n_cmp = 0;
  int n_err = 0;

  data_cache dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .miss(miss), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .access_count(access_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Memory model: word w of line n is 0xA000_0000 | n<<8 | w unless overridden.
  logic [255:0] model [64];
  int           lat_rd = 4, lat_wb = 2, cnt = 0;
  int           wb_count = 0, wb_before_fetch = 0;
  logic [26:0]  wb_addr = '0, fetch_addr = '0;
  logic [255:0] wb_data = '0;

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      cnt++;
      if (cnt >= (mem_we ? lat_wb : lat_rd)) begin
        cnt = 0;
        mem_ack = 1'b1;
        if (mem_we) begin
          model[mem_addr[5:0]] = mem_wdata;
          wb_count++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
        end else begin
          mem_rdata = model[mem_addr[5:0]];
          fetch_addr = mem_addr;
          wb_before_fetch = wb_count;
        end
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic do_reset();
    rst = 1'b1; rd_req = 1'b0; wr_req = 4'b0; addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wb_count = 0;
  endtask

  // One access held until miss drops; returns load data and number of miss cycles.
  task automatic access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rdat, output int mc);
    @(posedge clk); #1;
    rd_req = rd; wr_req = be; addr = a; wr_data = d;
    mc = 0; rdat = 'x;
    forever begin
      @(negedge clk);
      if (!miss) begin rdat = rd_data; break; end
      mc++;
      if (mc > 100) begin
        n_cmp++; n_err++;
        $display("FAIL timeout addr=%h: miss still high after %0d cycles", a, mc);
        break;
      end
    end
    @(posedge clk); #1;
    rd_req = 1'b0; wr_req = 4'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    n_cmp++; if (miss !== 1'b0) begin n_err++; $display("FAIL reset_miss got %b want 0", miss); end
    n_cmp++; if (access_count !== 32'd0) begin n_err++; $display("FAIL reset_access got %0d want 0", access_count); end
    n_cmp++; if (miss_count !== 32'd0) begin n_err++; $display("FAIL reset_miss_count got %0d want 0", miss_count); end
  endtask

  task automatic test_cold_read();
    logic [31:0] r; int mc;
    access(1'b1, 4'b0, 32'h40, 32'h0, r, mc);
    n_cmp++; if (mc !== 6) begin n_err++; $display("FAIL cold_miss_cycles got %0d want 6", mc); end
    n_cmp++; if (r !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cold_rdata got %h want deadbeef", r); end
    n_cmp++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL cold_miss_count got %0d want 1", miss_count); end
    n_cmp++; if (access_count !== 32'd1) begin n_err++; $display("FAIL cold_access got %0d want 1", access_count); end
  endtask

  task automatic test_store_merge();
    logic [31:0] r; int mc;
    access(1'b0, 4'b0110, 32'h44, 32'hAABB_CCDD, r, mc);
    n_cmp++; if (mc !== 0) begin n_err++; $display("FAIL store_hit_miss got %0d cycles want 0", mc); end
    access(1'b1, 4'b0, 32'h44, 32'h0, r, mc);
    n_cmp++; if (mc !== 0) begin n_err++; $display("FAIL merge_read_miss got %0d cycles want 0", mc); end
    n_cmp++; if (r !== 32'h11BB_CC44) begin n_err++; $display("FAIL merge_rdata got %h want 11bbcc44", r); end
    n_cmp++; if (access_count !== 32'd3) begin n_err++; $display("FAIL merge_access got %0d want 3", access_count); end
    n_cmp++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL merge_miss_count got %0d want 1", miss_count); end
  endtask

  task automatic test_lru();
    logic [31:0] r; int mc;
    do_reset();
    access(1'b1, 4'b0, 32'h000, 32'h0, r, mc);
    n_cmp++; if (r !== 32'hA000_0000) begin n_err++; $display("FAIL lru_rd000 got %h want a0000000", r); end
    access(1'b1, 4'b0, 32'h100, 32'h0, r, mc);
    n_cmp++; if (r !== 32'hA000_0800) begin n_err++; $display("FAIL lru_rd100 got %h want a0000800", r); end
    access(1'b1, 4'b0, 32'h000, 32'h0, r, mc);
    n_cmp++; if (mc !== 0) begin n_err++; $display("FAIL lru_rehit000 got %0d cycles want 0", mc); end
    access(1'b1, 4'b0, 32'h200, 32'h0, r, mc);
    n_cmp++; if (mc !== 6 || r !== 32'hA000_1000) begin n_err++; $display("FAIL lru_rd200 got %0d/%h want 6/a0001000", mc, r); end
    access(1'b1, 4'b0, 32'h000, 32'h0, r, mc);
    n_cmp++; if (mc !== 0 || r !== 32'hA000_0000) begin n_err++; $display("FAIL lru_keep000 got %0d/%h want 0/a0000000", mc, r); end
    access(1'b1, 4'b0, 32'h100, 32'h0, r, mc);
    n_cmp++; if (mc !== 6) begin n_err++; $display("FAIL lru_evicted100 got %0d cycles want 6", mc); end
    n_cmp++; if (wb_count !== 0) begin n_err++; $display("FAIL lru_no_wb got %0d writebacks want 0", wb_count); end
    n_cmp++; if (miss_count !== 32'd4 || access_count !== 32'd6) begin n_err++; $display("FAIL lru_counts got %0d/%0d want 4/6", miss_count, access_count); end
  endtask

  task automatic test_dirty_writeback();
    logic [31:0] r; int mc;
    do_reset();
    access(1'b0, 4'b1111, 32'h000, 32'h5555_5555, r, mc);
    n_cmp++; if (mc !== 6) begin n_err++; $display("FAIL wb_store_miss got %0d cycles want 6", mc); end
    access(1'b1, 4'b0, 32'h100, 32'h0, r, mc);
    access(1'b1, 4'b0, 32'h200, 32'h0, r, mc);
    n_cmp++; if (mc !== 8) begin n_err++; $display("FAIL wb_dirty_miss got %0d cycles want 8", mc); end
    n_cmp++; if (wb_count !== 1) begin n_err++; $display("FAIL wb_count got %0d want 1", wb_count); end
    n_cmp++; if (wb_addr !== 27'd0) begin n_err++; $display("FAIL wb_addr got %h want 0", wb_addr); end
    n_cmp++; if (wb_data[31:0] !== 32'h5555_5555) begin n_err++; $display("FAIL wb_word0 got %h want 55555555", wb_data[31:0]); end
    n_cmp++; if (wb_data[63:32] !== 32'hA000_0001) begin n_err++; $display("FAIL wb_word1 got %h want a0000001", wb_data[63:32]); end
    n_cmp++; if (fetch_addr !== 27'd16 || wb_before_fetch !== 1) begin n_err++; $display("FAIL wb_then_fetch got %h/%0d want 10/1", fetch_addr, wb_before_fetch); end
    n_cmp++; if (r !== 32'hA000_1000) begin n_err++; $display("FAIL wb_rd200 got %h want a0001000", r); end
    access(1'b1, 4'b0, 32'h000, 32'h0, r, mc);
    n_cmp++; if (mc !== 6 || r !== 32'h5555_5555) begin n_err++; $display("FAIL wb_refetch000 got %0d/%h want 6/55555555", mc, r); end
  endtask

  task automatic test_reset_swap_in();
    logic [31:0] r; int mc;
    do_reset();
    lat_rd = 20;
    @(posedge clk); #1;
    rd_req = 1'b1; addr = 32'h40;
    repeat (3) @(posedge clk);
    #1 rd_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin n_err++; $display("FAIL rs_fetching got req=%b we=%b want 1/0", mem_req, mem_we); end
    n_cmp++; if (miss !== 1'b1) begin n_err++; $display("FAIL rs_miss_held got %b want 1", miss); end
    n_cmp++; if (miss_count !== 32'd1) begin n_err++; $display("FAIL rs_pre_count got %0d want 1", miss_count); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rs_mem_req got %b want 0", mem_req); end
    n_cmp++; if (miss_count !== 32'd0 || access_count !== 32'd0) begin n_err++; $display("FAIL rs_counts got %0d/%0d want 0/0", miss_count, access_count); end
    lat_rd = 4;
    access(1'b1, 4'b0, 32'h40, 32'h0, r, mc);
    n_cmp++; if (mc !== 6 || r !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rs_reread got %0d/%h want 6/deadbeef", mc, r); end
  endtask

  task automatic test_write_miss();
    logic [31:0] r; int mc;
    do_reset();
    access(1'b0, 4'b0001, 32'h300, 32'h0000_00EE, r, mc);
    n_cmp++; if (mc !== 6) begin n_err++; $display("FAIL wm_cycles got %0d want 6", mc); end
    n_cmp++; if (miss_count !== 32'd1 || access_count !== 32'd1) begin n_err++; $display("FAIL wm_counts got %0d/%0d want 1/1", miss_count, access_count); end
    access(1'b1, 4'b0, 32'h300, 32'h0, r, mc);
    n_cmp++; if (mc !== 0 || r !== 32'hA000_18EE) begin n_err++; $display("FAIL wm_readback got %0d/%h want 0/a00018ee", mc, r); end
    access(1'b1, 4'b0, 32'h400, 32'h0, r, mc);
    access(1'b1, 4'b0, 32'h500, 32'h0, r, mc);
    n_cmp++; if (mc !== 8 || wb_count !== 1) begin n_err++; $display("FAIL wm_dirty_evict got %0d cycles/%0d wb want 8/1", mc, wb_count); end
    n_cmp++; if (wb_addr !== 27'd24 || wb_data[31:0] !== 32'hA000_18EE) begin n_err++; $display("FAIL wm_wb_line got %h/%h want 18/a00018ee", wb_addr, wb_data[31:0]); end
  endtask

  initial begin
    for (int n = 0; n < 64; n++)
      for (int w = 0; w < 8; w++)
        model[n][w*32 +: 32] = 32'hA000_0000 | (n << 8) | w;
    model[2][31:0]  = 32'hDEAD_BEEF;
    model[2][63:32] = 32'h1122_3344;

    test_reset();
    test_cold_read();
    test_store_merge();
    test_lru();
    test_dirty_writeback();
    test_reset_swap_in();
    test_write_miss();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_cache.md
# data_cache

Write-back, write-allocate, 2-way set-associative data cache for the MEM stage of the RV32I pipeline. It serves load/store requests from the core's MEM stage and raises `miss` to the hazard unit, which stalls the whole pipeline. On a miss it refills whole lines over a line-wide request/acknowledge interface to main memory, writing back a dirty victim first.

## Interface
**Parameters**
- LINE_ADDR_LEN, 3 — log2 of words per line (default 8 words = 256-bit line).
- SET_ADDR_LEN, 3 — log2 of set count (default 8 sets).
- Derived: TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN; LINE_W = 32 << LINE_ADDR_LEN.

**Ports**
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — reset, synchronous and active-high.
- rd_req  in  1  — load request from MEM stage.
- wr_req  in  4  — store byte enables (cache_write_en); any bit set means a write request.
- addr  in  32  — byte address; addr[1:0] is ignored for reads.
- wr_data  in  32  — store data, byte lanes as in the register.
- rd_data  out  32  — load word, combinational; valid only when a read request is present and miss=0.
- miss  out  1  — combinational; high while the current request is not yet satisfied.
- mem_req  out  1  — memory transaction request; held until mem_ack.
- mem_we  out  1  — 1 = line write-back, 0 = line fetch; stable while mem_req is high.
- mem_addr  out  30-LINE_ADDR_LEN  — line address {tag,set}; stable while mem_req is high.
- mem_wdata  out  LINE_W  — victim line; stable while mem_req is high.
- mem_rdata  in  LINE_W  — fetched line; sampled on the mem_ack cycle.
- mem_ack  in  1  — one-cycle completion pulse.
- access_count  out  32  — performance counter: accesses completed.
- miss_count  out  32  — performance counter: misses.

## Operation
- Address split: word offset addr[LINE_ADDR_LEN+1:2]; set index next SET_ADDR_LEN bits; tag is the remaining upper bits.
- Per way and set: valid bit, dirty bit, tag, line. Per set: one LRU bit that names the least-recently-used way.
- Request = rd_req | (|wr_req). If rd_req and wr_req arrive together, the request is a write and rd_data is don't-care.
- Hit = request, state IDLE, and some way valid with a matching tag. Way 0 wins if both match (cannot occur in normal operation).
- miss = request & ~hit.
- **Read hit:** rd_data is the addressed word; LRU bit ← the other way.
- **Write hit:** at the edge, merge the enabled bytes into the word, set dirty, and LRU bit ← the other way.
- **Victim selection:** invalid way 0, else invalid way 1, else the LRU way.
- **FSM states:**
  - IDLE: on a request that misses, latch the line address and the victim way.
    - If the victim is valid and dirty, go to SWAP_OUT.
    - Otherwise, go to SWAP_IN.
    - Increment miss_count on this edge.
  - SWAP_OUT: mem_req=1, mem_we=1, mem_addr = {victim tag, set}, mem_wdata = victim line. On mem_ack, go to SWAP_IN.
  - SWAP_IN: mem_req=1, mem_we=0, mem_addr = requested line. On mem_ack, capture mem_rdata and go to INSTALL.
  - INSTALL: write the line, tag, valid=1 and dirty=0 into the victim way; LRU bit ← the other way; go to IDLE.
- After INSTALL the held request hits in IDLE and completes as a normal hit. A write miss therefore becomes a write hit and sets dirty.
- The core holds addr, rd_req, wr_req and wr_data constant while miss=1.
- access_count increments on every edge at which hit=1. The core advances on that edge, so each access is counted exactly once.
- Counters wrap modulo 2^32.

## Timing
- Reset (rst=1 at an edge), also mid-transaction:
  - state ← IDLE; all valid, dirty and LRU bits ← 0; both counters ← 0.
  - mem_req is 0 in the following cycle. An outstanding memory transaction is abandoned, and memory must tolerate this.
- Output values after reset: mem_req=0, mem_we=0, miss=0 with no request, access_count=0, miss_count=0.
- Hit latency: 0 cycles. Data and miss=0 appear in the request cycle; the write commits at the following edge.
- Clean miss with memory latency L cycles (mem_ack L cycles after mem_req rises): miss is high for 1 (IDLE) + L (SWAP_IN) + 1 (INSTALL) cycles, then low in the next IDLE cycle.
- Dirty miss: adds the SWAP_OUT duration, L_wb cycles.
- mem_ack is ignored in IDLE and INSTALL.
- mem_req drops in the cycle after mem_ack.
- In non-IDLE states miss=1 even if the request line is low, e.g. when the request is held by a stall.

## Test plan
- **Cold read miss:** after reset, rd_req at addr 0x0000_0040; memory returns a line with word0 = 0xDEAD_BEEF, L=4.
  - miss is high for 6 cycles.
  - rd_data = 0xDEAD_BEEF.
  - miss_count=1, access_count=1.
- **Store hit merge:** line present holding 0x1122_3344; wr_req=4'b0110, wr_data=0xAABB_CCDD.
  - miss=0.
  - A subsequent read returns 0x11BB_CC44.
- **LRU eviction:** read 0x000, then 0x100, then re-read 0x000 (same set, different tags, default parameters), then read 0x200.
  - The line for 0x100 is evicted.
  - Re-reading 0x000 is a hit.
- **Dirty write-back:**
  - Store 0x5555_5555 to 0x000, then miss 0x100, then miss 0x200, so both ways are filled and the dirty line is victimised.
  - SWAP_OUT must show mem_we=1, mem_addr = the line address of 0x000, and the word = 0x5555_5555.
  - This is followed by a fetch of 0x200.
- **Reset during SWAP_IN:** assert rst while mem_req=1.
  - The next cycle has mem_req=0 and counters at 0.
  - A re-read of the same address misses again.
- **Write miss allocate:** store to an uncached line.
  - Fetch, then install, then the write commits.
  - Line is dirty; miss_count increments by 1 and access_count by 1.
